// File: rtl/kbd_ctrl.sv
// PS/2 scan-code sequencer: pops the receiver FIFO, decodes E0/F0 prefixes and modifiers,
// and queues key events for the CPU. Define KBD_BREAK_EVENT_EN to also queue break events.
module kbd_ctrl #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  ps2_ready,
    input  logic [7:0]            ps2_data,
    output logic                  ps2_nextdata_n,
    input  logic                  cpu_rd,
    input  logic                  cpu_clr_ovf,
    output logic                  key_valid,
    output logic [7:0]            key_code,
    output logic                  key_ext,
    output logic                  key_shift,
    output logic                  key_caps,
    output logic                  key_brk,
    output logic                  shift_state,
    output logic                  caps_state,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   fifo_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef KBD_BREAK_EVENT_EN
    localparam int EW = 12;
`else
    localparam int EW = 11;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POP  = 2'd1;
    localparam logic [1:0] S_DEC  = 2'd2;

    logic [1:0]            state;
    logic [7:0]            byte_r;
    logic                  ext_pend, brk_pend, shift_l, shift_r, caps;
    logic                  ext_nxt, brk_nxt, shl_nxt, shr_nxt, caps_nxt;
    logic                  push_req, is_junk;
    logic [EW-1:0]         ent;
    logic [EW-1:0]         mem [DEPTH];
    logic [EW-1:0]         head;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  full, empty, do_push, do_pop, drop;

    // Consumer FSM: POP is a guard cycle so the receiver can advance its head.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state          <= S_IDLE;
            byte_r         <= 8'h00;
            ps2_nextdata_n <= 1'b1;
        end else begin
            case (state)
                S_IDLE: if (ps2_ready) begin
                    byte_r         <= ps2_data;
                    ps2_nextdata_n <= 1'b0;
                    state          <= S_POP;
                end
                S_POP: begin
                    ps2_nextdata_n <= 1'b1;
                    state          <= S_DEC;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        is_junk  = byte_r inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
        push_req = 1'b0;
        ext_nxt  = ext_pend;
        brk_nxt  = brk_pend;
        shl_nxt  = shift_l;
        shr_nxt  = shift_r;
        caps_nxt = caps;
`ifdef KBD_BREAK_EVENT_EN
        ent = {brk_pend, caps, shift_l | shift_r, ext_pend, byte_r};
`else
        ent = {caps, shift_l | shift_r, ext_pend, byte_r};
`endif
        if (state == S_DEC) begin
            if (byte_r == 8'hE0) begin
                ext_nxt = 1'b1;
            end else if (byte_r == 8'hF0) begin
                brk_nxt = 1'b1;
            end else begin
                ext_nxt = 1'b0;
                brk_nxt = 1'b0;
                if (!ext_pend && byte_r == 8'h12) begin
                    shl_nxt = !brk_pend;
                end else if (!ext_pend && byte_r == 8'h59) begin
                    shr_nxt = !brk_pend;
                end else if (!ext_pend && byte_r == 8'h58) begin
                    if (!brk_pend) caps_nxt = !caps;
                end else if (!is_junk) begin
`ifdef KBD_BREAK_EVENT_EN
                    push_req = 1'b1;
`else
                    push_req = !brk_pend;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            shift_l  <= 1'b0;
            shift_r  <= 1'b0;
            caps     <= 1'b0;
        end else begin
            ext_pend <= ext_nxt;
            brk_pend <= brk_nxt;
            shift_l  <= shl_nxt;
            shift_r  <= shr_nxt;
            caps     <= caps_nxt;
        end
    end

    assign full    = (fifo_count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (fifo_count == '0);
    // A read of a full FIFO frees the slot the simultaneous push needs.
    assign do_push = push_req && (!full || cpu_rd);
    assign do_pop  = cpu_rd && !empty;
    assign drop    = push_req && full && !cpu_rd;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      fifo_count <= fifo_count + 1'b1;
            else if (do_pop && !do_push) fifo_count <= fifo_count - 1'b1;
            if (drop)             overflow <= 1'b1;
            else if (cpu_clr_ovf) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= ent;
    end

    // Head is gated so stale storage never leaks out while empty.
    assign key_valid = !empty;
    assign head      = key_valid ? mem[rd_ptr] : '0;
    assign key_code  = head[7:0];
    assign key_ext   = head[8];
    assign key_shift = head[9];
    assign key_caps  = head[10];
`ifdef KBD_BREAK_EVENT_EN
    assign key_brk   = head[11];
`else
    assign key_brk   = 1'b0;
`endif

    assign shift_state = shift_l | shift_r;
    assign caps_state  = caps;

endmodule

// File: tb/tb_kbd_ctrl.sv
// Directed self-checking bench for kbd_ctrl: scan-code vector table plus FIFO/reset sequences.
module tb_kbd_ctrl;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_ready = 1'b0;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_nextdata_n;
    logic       cpu_rd = 1'b0;
    logic       cpu_clr_ovf = 1'b0;
    logic       key_valid, key_ext, key_shift, key_caps, key_brk;
    logic [7:0] key_code;
    logic       shift_state, caps_state, overflow;
    logic [3:0] fifo_count;

    int checks = 0;
    int errors = 0;

`ifdef KBD_BREAK_EVENT_EN
    localparam int OPT = 1;
`else
    localparam int OPT = 0;
`endif

    kbd_ctrl #(.DEPTH_LOG2(3)) dut (
        .clk(clk), .clrn(clrn), .ps2_ready(ps2_ready), .ps2_data(ps2_data),
        .ps2_nextdata_n(ps2_nextdata_n), .cpu_rd(cpu_rd), .cpu_clr_ovf(cpu_clr_ovf),
        .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
        .key_shift(key_shift), .key_caps(key_caps), .key_brk(key_brk),
        .shift_state(shift_state), .caps_state(caps_state), .overflow(overflow),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [47:0] seq;
        int          len;
        int          cnt;
        logic [7:0]  code;
        logic        ext, shift, caps, shift_st, caps_st;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        clrn = 1'b0; ps2_ready = 1'b0; cpu_rd = 1'b0; cpu_clr_ovf = 1'b0;
        @(negedge clk); @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    // rd/clr are held high across the edge on which this byte is decoded.
    task automatic send(input logic [7:0] b, input logic rd, input logic clr);
        int n;
        ps2_data = b; ps2_ready = 1'b1; n = 0;
        @(negedge clk);
        while (ps2_nextdata_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ps2_nextdata_n) begin
            chk("pop_timeout", 32'(ps2_nextdata_n), 32'd0);
            ps2_ready = 1'b0;
            return;
        end
        ps2_ready = 1'b0; ps2_data = 8'h00;
        @(negedge clk);
        chk("pop_pulse_end", 32'(ps2_nextdata_n), 32'd1);
        cpu_rd = rd; cpu_clr_ovf = clr;
        @(negedge clk);
        cpu_rd = 1'b0; cpu_clr_ovf = 1'b0;
    endtask

    task automatic pop_one();
        cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
    endtask

    function automatic vec_t mk(string nm, logic [47:0] s, int len, int cnt, logic [7:0] code,
                                logic ext, logic sh, logic cp, logic shs, logic cps);
        vec_t v;
        v.name = nm; v.seq = s; v.len = len; v.cnt = cnt; v.code = code;
        v.ext = ext; v.shift = sh; v.caps = cp; v.shift_st = shs; v.caps_st = cps;
        return v;
    endfunction

    vec_t vecs[7];
    logic [7:0] exp_rd[8];

    initial begin
        vecs[0] = mk("make_break", {8'h1C, 8'hF0, 8'h1C, 24'h0}, 3, 1 + OPT, 8'h1C, 0, 0, 0, 0, 0);
        vecs[1] = mk("shifted", {8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12}, 6, 1 + OPT, 8'h1C, 0, 1, 0, 0, 0);
        vecs[2] = mk("extended", {8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h00}, 5, 1 + OPT, 8'h75, 1, 0, 0, 0, 0);
        vecs[3] = mk("caps", {8'h58, 8'hF0, 8'h58, 8'h1C, 16'h0}, 4, 1, 8'h1C, 0, 0, 1, 0, 1);
        vecs[4] = mk("rshift_junk", {8'h59, 8'hAA, 8'h1C, 24'h0}, 3, 1, 8'h1C, 0, 1, 0, 1, 0);
        vecs[5] = mk("ext_12", {8'hE0, 8'h12, 32'h0}, 2, 1, 8'h12, 1, 0, 0, 0, 0);
        vecs[6] = mk("junk_clr_brk", {8'hF0, 8'hFA, 8'h1C, 24'h0}, 3, 1, 8'h1C, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) exp_rd[i] = 8'h16 + 8'(i);
        exp_rd[7] = 8'h24;

        do_reset();
        chk("rst_nextdata_n", 32'(ps2_nextdata_n), 32'd1);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_code", 32'(key_code), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            for (int j = 0; j < vecs[i].len; j++) send(vecs[i].seq[47-8*j -: 8], 1'b0, 1'b0);
            chk({vecs[i].name, "_count"}, 32'(fifo_count), 32'(vecs[i].cnt));
            chk({vecs[i].name, "_valid"}, 32'(key_valid), 32'd1);
            chk({vecs[i].name, "_code"}, 32'(key_code), 32'(vecs[i].code));
            chk({vecs[i].name, "_ext"}, 32'(key_ext), 32'(vecs[i].ext));
            chk({vecs[i].name, "_shift"}, 32'(key_shift), 32'(vecs[i].shift));
            chk({vecs[i].name, "_caps"}, 32'(key_caps), 32'(vecs[i].caps));
            chk({vecs[i].name, "_brk"}, 32'(key_brk), 32'd0);
            chk({vecs[i].name, "_shift_st"}, 32'(shift_state), 32'(vecs[i].shift_st));
            chk({vecs[i].name, "_caps_st"}, 32'(caps_state), 32'(vecs[i].caps_st));
        end

`ifdef KBD_BREAK_EVENT_EN
        do_reset();
        send(8'hE0, 0, 0); send(8'h75, 0, 0); send(8'hE0, 0, 0); send(8'hF0, 0, 0); send(8'h75, 0, 0);
        pop_one();
        chk("brkev_code", 32'(key_code), 32'h75);
        chk("brkev_ext", 32'(key_ext), 32'd1);
        chk("brkev_brk", 32'(key_brk), 32'd1);
`endif

        // Overflow, full-FIFO concurrent read/push, ordering, sticky flag.
        do_reset();
        for (int i = 0; i < 9; i++) send(8'h15 + 8'(i), 1'b0, 1'b0);
        chk("ovf_count", 32'(fifo_count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_head", 32'(key_code), 32'h15);
        send(8'h1E, 1'b0, 1'b1);
        chk("ovf_clr_vs_drop", 32'(overflow), 32'd1);
        chk("ovf_count2", 32'(fifo_count), 32'd8);
        send(8'h24, 1'b1, 1'b0);
        chk("full_rdpush_count", 32'(fifo_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("read_%0d", i), 32'(key_code), 32'(exp_rd[i]));
            pop_one();
        end
        chk("drain_count", 32'(fifo_count), 32'd0);
        chk("drain_valid", 32'(key_valid), 32'd0);
        chk("drain_code", 32'(key_code), 32'd0);
        pop_one();
        chk("rd_empty_count", 32'(fifo_count), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        cpu_clr_ovf = 1'b1;
        @(negedge clk);
        cpu_clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Reset between prefix and code drops the prefix.
        send(8'hE0, 1'b0, 1'b0);
        clrn = 1'b0;
        #1;
        chk("midrst_nextdata_n", 32'(ps2_nextdata_n), 32'd1);
        @(negedge clk);
        chk("midrst_nextdata_n2", 32'(ps2_nextdata_n), 32'd1);
        clrn = 1'b1;
        @(negedge clk);
        send(8'h75, 1'b0, 1'b0);
        chk("midrst_code", 32'(key_code), 32'h75);
        chk("midrst_ext", 32'(key_ext), 32'd0);

        // Push into empty FIFO with cpu_rd high: pop is ignored.
        pop_one();
        send(8'h2B, 1'b1, 1'b0);
        chk("empty_rdpush_count", 32'(fifo_count), 32'd1);
        chk("empty_rdpush_code", 32'(key_code), 32'h2B);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kbd_ctrl.md
Name: kbd_ctrl

Overview:
Sequences the PS/2 receiver's scan-code FIFO for the single-cycle CPU. It pops bytes with the receiver's ready/nextdata_n handshake and decodes the E0 (extended) and F0 (break) prefixes. It tracks the Shift and Caps Lock modifiers and queues decoded key-press events in a small FIFO that the CPU reads through a memory-mapped read strobe. It replaces ad-hoc scan-code handling in the keyboard path; ASCII translation stays downstream.

Parameters:
DEPTH_LOG2, 3, log2 of key-event FIFO depth (default 8 entries)

Ports:
clk  in  1  system clock, all state on rising edge
clrn  in  1  asynchronous active-low reset
ps2_ready  in  1  receiver FIFO non-empty
ps2_data  in  8  scan code at receiver FIFO head
ps2_nextdata_n  out  1  active-low one-cycle pop pulse to receiver
cpu_rd  in  1  CPU read strobe; pops one key event
cpu_clr_ovf  in  1  clears the overflow flag
key_valid  out  1  key FIFO non-empty
key_code  out  8  scan code of head entry (show-ahead)
key_ext  out  1  head entry was E0-prefixed
key_shift  out  1  Shift held when head entry was decoded
key_caps  out  1  Caps Lock on when head entry was decoded
key_brk  out  1  head entry is a break event (always 0 without option)
shift_state  out  1  live Shift (left OR right)
caps_state  out  1  live Caps Lock toggle
overflow  out  1  sticky: an event was dropped because FIFO full
fifo_count  out  DEPTH_LOG2+1  entries held

Behaviour:
- Reset (clrn=0, asynchronous): state IDLE; ps2_nextdata_n=1. Pointers, count, prefix flags, shift_l, shift_r, caps, overflow and all key_* outputs go to 0. An in-flight byte is lost.
- Consumer FSM, one byte per 3 cycles:
  - IDLE: if ps2_ready, capture ps2_data into byte_r, drive ps2_nextdata_n=0, go to POP.
  - POP: ps2_nextdata_n=1; ps2_ready is ignored (guard cycle for receiver update); go to DECODE.
  - DECODE: process byte_r per the rules below; go to IDLE.
- Latency: ps2_ready sampled at edge N; push occurs at edge N+2; key_valid is high after edge N+2 when the FIFO was previously empty.
- Decode rules (ext_pend and brk_pend are the prefix flags):
  - 0xE0: set ext_pend.
  - 0xF0: set brk_pend.
  - 0x12 or 0x59 with ext_pend=0: shift_l or shift_r set on make, cleared on break; no push; clear both prefix flags.
  - 0x58 make with ext_pend=0: toggle caps; break ignored; no push; clear prefix flags.
  - 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF: discard and clear prefix flags.
  - Any other byte with brk_pend=1: no push (option below changes this); clear prefix flags.
  - Any other byte as a make: push {caps, shift_l|shift_r, ext_pend, byte_r}; clear prefix flags.
  - Typematic repeats push again.
- FIFO: circular buffer; pointers wrap modulo 2^DEPTH_LOG2.
  - Push when not full, or when full with cpu_rd in the same cycle; count is unchanged in that case.
  - Push while full with no cpu_rd: event dropped, overflow set.
  - cpu_rd while empty is ignored.
  - Push and pop in the same cycle: count unchanged.
  - Push to an empty FIFO with cpu_rd high: the push succeeds and the pop is ignored.
  - overflow stays set until cpu_clr_ovf. If cpu_clr_ovf and a new drop coincide, the flag stays set.
- key_* outputs are driven combinationally from the head entry; they are 0 when empty.

Optional Feature:
KBD_BREAK_EVENT_EN.
- Defined: entries carry a brk bit. Non-modifier break codes are pushed with key_brk=1, and the modifier and prefix handling is unchanged.
- Undefined: break events are never queued, and key_brk is tied to 0.

Test Plan:
- Stream 1C, F0, 1C -> one entry: key_code=1C, ext=0, shift=0, caps=0; fifo_count=1.
- Stream 12, 1C, F0, 1C, F0, 12 -> one entry 1C with key_shift=1; final shift_state=0; fifo_count=1.
- Stream E0, 75, E0, F0, 75 -> one entry: key_code=75, key_ext=1. With KBD_BREAK_EVENT_EN, a second entry: key_code=75, ext=1, brk=1.
- Stream 58, F0, 58, 1C -> caps_state=1; entry 1C with key_caps=1.
- Nine make codes 15..1D with no cpu_rd -> count=8, overflow=1, 1D dropped. Then cpu_rd concurrent with a push of 24 -> count stays 8. Reads return 16..1C then 24 in order. cpu_clr_ovf -> overflow=0.
- Send E0, pulse clrn low for 1 cycle, then send 75 -> entry key_code=75 with ext=0; ps2_nextdata_n=1 throughout reset.
